// File: rtl/dram_cmd_pkg.sv
// Shared definitions for the per-bank DRAM command sequencer: command
// encodings on the {cs,ras,cas,we} lines, FSM states and timer width.
package dram_cmd_pkg;

    // 4-bit command encodings, ordered {cs, ras, cas, we}
    typedef enum logic [3:0] {
        CMD_REF = 4'b0001,
        CMD_PRE = 4'b0010,
        CMD_ACT = 4'b0011,
        CMD_WR  = 4'b0100,
        CMD_RD  = 4'b0101,
        CMD_NOP = 4'b1111
    } cmd_e;

    localparam logic [3:0] CMD_NOP_ENC = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_PRE_WAIT,
        ST_ACT,
        ST_ACT_WAIT,
        ST_COL,
        ST_REF,
        ST_REF_WAIT
    } state_e;

    localparam int TIMER_W = 16;

endpackage

// File: rtl/bank_command_sequencer_if.sv
// Request and command bundle of one bank sequencer. The slave modport is the
// sequencer's view; master is the request source / command sink side.
interface bank_command_sequencer_if #(
    parameter int ROW_BITS = 14
) ();
    logic                req_valid;
    logic                req_ready;
    logic                req_is_write;
    logic [31:0]         req_addr;
    logic [31:0]         req_data;
    logic [31:0]         req_id;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [31:0]         cmd_addr;
    logic [31:0]         cmd_data;
    logic [31:0]         cmd_request_id;
    logic                cmd_cs;
    logic                cmd_ras;
    logic                cmd_cas;
    logic                cmd_we;
    logic                row_open;
    logic [ROW_BITS-1:0] open_row;
    logic                busy;

    modport slave (
        input  req_valid, req_is_write, req_addr, req_data, req_id, cmd_ready,
        output req_ready, cmd_valid, cmd_addr, cmd_data, cmd_request_id,
               cmd_cs, cmd_ras, cmd_cas, cmd_we, row_open, open_row, busy
    );

    modport master (
        output req_valid, req_is_write, req_addr, req_data, req_id, cmd_ready,
        input  req_ready, cmd_valid, cmd_addr, cmd_data, cmd_request_id,
               cmd_cs, cmd_ras, cmd_cas, cmd_we, row_open, open_row, busy
    );
endinterface

// File: rtl/bank_timer.sv
// Loadable down counter that saturates at zero. zero_o marks an elapsed
// constraint; expiring_o marks the last cycle before (or at) zero so a wait
// state can hand over early and the issue state sees zero on arrival.
module bank_timer
    import dram_cmd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               zero_o,
    output logic               expiring_o
);
    logic [TIMER_W-1:0] count_q;

    // Load has priority over the countdown; hold at zero once reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o     = (count_q == '0);
    assign expiring_o = (count_q <= TIMER_W'(1));
endmodule

// File: rtl/bank_command_sequencer.sv
// Per-bank sequencer: turns read/write requests into ACT/RD/WR/PRE commands
// under an open-page policy and inserts periodic REFRESH.
module bank_command_sequencer
    import dram_cmd_pkg::*;
#(
    parameter int RANK      = 0,
    parameter int BANKGROUP = 0,
    parameter int BANK      = 0,
    parameter int ROW_SHIFT = 10,
    parameter int ROW_BITS  = 14,
    parameter int T_RCD     = 14,
    parameter int T_RP      = 14,
    parameter int T_RAS     = 33,
    parameter int T_RFC     = 160,
    parameter int T_REFI    = 3900
) (
    input  logic                     clk,
    input  logic                     reset,
    bank_command_sequencer_if.slave  bus
);
    // A misconfigured instance refuses all traffic instead of issuing
    // commands with nonsensical timing.
    localparam bit CFG_OK = (RANK >= 0) && (BANKGROUP >= 0) && (BANK >= 0) &&
                            (T_RCD >= 1) && (T_RP >= 1) && (T_RAS >= 1) &&
                            (T_RFC >= 1) && (T_REFI > T_RFC);

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  refi_q;
    logic                refresh_pending_q;
    logic                ref_path_q;
    logic                row_open_q;
    logic [ROW_BITS-1:0] open_row_q;
    logic                is_write_q;
    logic [31:0]         addr_q, data_q, id_q;

    logic                req_ready_c, accept, fire, cmd_valid_c, row_hit;
    logic [ROW_BITS-1:0] req_row, lat_row;
    cmd_e                cmd_enc;
    logic [31:0]         cmd_addr_c, cmd_data_c, cmd_id_c;
    logic                wait_load, ras_load;
    logic [TIMER_W-1:0]  wait_val;
    logic                wait_zero, wait_expiring, ras_zero, ras_expiring_unused;

    assign req_row     = bus.req_addr[ROW_SHIFT +: ROW_BITS];
    assign lat_row     = addr_q[ROW_SHIFT +: ROW_BITS];
    assign row_hit     = row_open_q && (req_row == open_row_q);
    assign req_ready_c = CFG_OK && (state_q == ST_IDLE) && !refresh_pending_q && !reset;
    assign accept      = bus.req_valid && req_ready_c;

    // PRE waits on tRAS; every other issue state waits on the shared timer
    assign cmd_valid_c = ((state_q == ST_PRE) && ras_zero) ||
                         ((state_q inside {ST_ACT, ST_COL, ST_REF}) && wait_zero);
    assign fire        = cmd_valid_c && bus.cmd_ready;

    bank_timer u_wait_timer (
        .clk(clk), .rst(reset), .load_i(wait_load), .load_val_i(wait_val),
        .zero_o(wait_zero), .expiring_o(wait_expiring)
    );

    bank_timer u_ras_timer (
        .clk(clk), .rst(reset), .load_i(ras_load), .load_val_i(TIMER_W'(T_RAS - 1)),
        .zero_o(ras_zero), .expiring_o(ras_expiring_unused)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: refresh is only taken between requests, never mid-request
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (refresh_pending_q)  state_d = row_open_q ? ST_PRE : ST_REF;
                else if (accept)        state_d = row_hit ? ST_COL :
                                                  (row_open_q ? ST_PRE : ST_ACT);
            end
            ST_PRE:      if (fire)          state_d = ST_PRE_WAIT;
            ST_PRE_WAIT: if (wait_expiring) state_d = ref_path_q ? ST_REF : ST_ACT;
            ST_ACT:      if (fire)          state_d = ST_ACT_WAIT;
            ST_ACT_WAIT: if (wait_expiring) state_d = ST_COL;
            ST_COL:      if (fire)          state_d = ST_IDLE;
            ST_REF:      if (fire)          state_d = ST_REF_WAIT;
            ST_REF_WAIT: if (wait_expiring) state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // Outputs: command encoding, payload and timer loads on fire
    always_comb begin
        cmd_enc    = CMD_NOP;
        cmd_addr_c = '0;
        cmd_data_c = '0;
        cmd_id_c   = '0;
        wait_load  = 1'b0;
        wait_val   = '0;
        ras_load   = 1'b0;
        case (state_q)
            ST_PRE: begin
                if (cmd_valid_c) begin
                    cmd_enc    = CMD_PRE;
                    cmd_addr_c = addr_q;
                    cmd_data_c = data_q;
                    cmd_id_c   = id_q;
                end
                wait_load = fire;
                wait_val  = TIMER_W'(T_RP - 1);
            end
            ST_ACT: begin
                if (cmd_valid_c) begin
                    cmd_enc    = CMD_ACT;
                    cmd_addr_c = addr_q;
                    cmd_data_c = data_q;
                    cmd_id_c   = id_q;
                end
                wait_load = fire;
                wait_val  = TIMER_W'(T_RCD - 1);
                ras_load  = fire;
            end
            ST_COL: begin
                if (cmd_valid_c) begin
                    cmd_enc    = is_write_q ? CMD_WR : CMD_RD;
                    cmd_addr_c = addr_q;
                    cmd_data_c = data_q;
                    cmd_id_c   = id_q;
                end
            end
            ST_REF: begin
                // REFRESH carries an all-zero payload
                if (cmd_valid_c) cmd_enc = CMD_REF;
                wait_load = fire;
                wait_val  = TIMER_W'(T_RFC - 1);
            end
            default: ;
        endcase
    end

    // Request latch, open-row tracking and refresh interval bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refi_q            <= '0;
            refresh_pending_q <= 1'b0;
            ref_path_q        <= 1'b0;
            row_open_q        <= 1'b0;
            open_row_q        <= '0;
            is_write_q        <= 1'b0;
            addr_q            <= '0;
            data_q            <= '0;
            id_q              <= '0;
        end else begin
            if (accept) begin
                is_write_q <= bus.req_is_write;
                addr_q     <= bus.req_addr;
                data_q     <= bus.req_data;
                id_q       <= bus.req_id;
            end
            if (state_q == ST_IDLE && refresh_pending_q && row_open_q) ref_path_q <= 1'b1;
            if (fire && state_q == ST_PRE) row_open_q <= 1'b0;
            if (fire && state_q == ST_ACT) begin
                row_open_q <= 1'b1;
                open_row_q <= lat_row;
            end
            if (fire && state_q == ST_REF) begin
                refresh_pending_q <= 1'b0;
                ref_path_q        <= 1'b0;
            end
            // A new interval expiry wins over a same-cycle REFRESH clear;
            // expiries while already pending collapse into the one flag.
            if (refi_q == TIMER_W'(T_REFI - 1)) begin
                refi_q            <= '0;
                refresh_pending_q <= 1'b1;
            end else begin
                refi_q <= refi_q + 1'b1;
            end
        end
    end

    assign bus.req_ready      = req_ready_c;
    assign bus.cmd_valid      = cmd_valid_c;
    assign {bus.cmd_cs, bus.cmd_ras, bus.cmd_cas, bus.cmd_we} = cmd_enc;
    assign bus.cmd_addr       = cmd_addr_c;
    assign bus.cmd_data       = cmd_data_c;
    assign bus.cmd_request_id = cmd_id_c;
    assign bus.row_open       = row_open_q;
    assign bus.open_row       = open_row_q;
    assign bus.busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_bank_command_sequencer.sv
// Directed bench: instance A runs default timing, instance B a short refresh
// interval (T_REFI=50, T_RFC=10) for the refresh sequence.
module tb_bank_command_sequencer;
    import dram_cmd_pkg::*;

    logic clk;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    bank_command_sequencer_if ia ();
    bank_command_sequencer_if ib ();

    bank_command_sequencer u_dut_a (
        .clk(clk), .reset(rst_a), .bus(ia.slave)
    );

    bank_command_sequencer #(.T_REFI(50), .T_RFC(10)) u_dut_b (
        .clk(clk), .reset(rst_b), .bus(ib.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] enc_of(input bit sel);
        return sel ? {ib.cmd_cs, ib.cmd_ras, ib.cmd_cas, ib.cmd_we}
                   : {ia.cmd_cs, ia.cmd_ras, ia.cmd_cas, ia.cmd_we};
    endfunction

    task automatic drive_req(input bit sel, input logic v, input logic wr,
                             input logic [31:0] addr, input logic [31:0] data, input logic [31:0] id);
        if (sel) begin
            ib.req_valid = v; ib.req_is_write = wr; ib.req_addr = addr; ib.req_data = data; ib.req_id = id;
        end else begin
            ia.req_valid = v; ia.req_is_write = wr; ia.req_addr = addr; ia.req_data = data; ia.req_id = id;
        end
    endtask

    task automatic send_req(input bit sel, input string tag, input logic wr,
                            input logic [31:0] addr, input logic [31:0] data, input logic [31:0] id,
                            output int acc);
        bit done;
        done = 1'b0;
        acc  = -1;
        @(negedge clk);
        drive_req(sel, 1'b1, wr, addr, data, id);
        for (int k = 0; k < 400 && !done; k++) begin
            if (sel ? ib.req_ready : ia.req_ready) begin
                acc  = cyc;
                done = 1'b1;
                @(posedge clk);
                #1;
            end else begin
                @(negedge clk);
            end
        end
        drive_req(sel, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        check_val({tag, "_accept"}, 64'(done), 64'd1);
        $display("[TB] %s: req wr=%0b addr=0x%08h id=%0d accepted at cycle %0d", tag, wr, addr, id, acc);
    endtask

    task automatic wait_fire(input bit sel, input string tag, output int fc, output logic [3:0] enc,
                             output logic [31:0] addr, output logic [31:0] data, output logic [31:0] id);
        bit got;
        got = 1'b0; fc = -1; enc = 4'hF; addr = '0; data = '0; id = '0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (sel ? (ib.cmd_valid && ib.cmd_ready) : (ia.cmd_valid && ia.cmd_ready)) begin
                got  = 1'b1;
                fc   = cyc;
                enc  = enc_of(sel);
                addr = sel ? ib.cmd_addr : ia.cmd_addr;
                data = sel ? ib.cmd_data : ia.cmd_data;
                id   = sel ? ib.cmd_request_id : ia.cmd_request_id;
            end
        end
        check_val({tag, "_fire"}, 64'(got), 64'd1);
        if (got) begin
            @(posedge clk);
            #1;
        end
        $display("[TB] %s: cmd %04b addr=0x%08h id=%0d fired at cycle %0d", tag, enc, addr, id, fc);
    endtask

    initial begin
        int          acc, f, t_act, t_pre, v, d, r;
        logic [3:0]  e;
        logic [31:0] a, dt, id;
        bit          seen;

        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        ia.cmd_ready = 1'b1;
        ib.cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_req_ready_low", 64'(ia.req_ready), 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        check_val("rst_cmd_valid", 64'(ia.cmd_valid), 64'd0);
        check_val("rst_bus_nop", 64'(enc_of(1'b0)), 64'hF);
        check_val("rst_cmd_addr", 64'(ia.cmd_addr), 64'd0);
        check_val("rst_row_open", 64'(ia.row_open), 64'd0);
        check_val("rst_open_row", 64'(ia.open_row), 64'd0);
        check_val("rst_busy", 64'(ia.busy), 64'd0);
        check_val("rst_req_ready_high", 64'(ia.req_ready), 64'd1);

        // ---- Refresh with a row open (instance B) ----
        send_req(1'b1, "b_rd", 1'b0, 32'h0000_0400, 32'h0, 32'd3, acc);
        wait_fire(1'b1, "b_act", t_act, e, a, dt, id);
        check_val("b_act_enc", 64'(e), 64'(CMD_ACT));
        wait_fire(1'b1, "b_read", f, e, a, dt, id);
        check_val("b_read_enc", 64'(e), 64'(CMD_RD));
        seen = 1'b0; d = -1;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (!ib.req_ready) begin
                seen = 1'b1;
                d    = cyc;
            end
        end
        check_val("b_ready_drop", 64'(seen), 64'd1);
        check_val("b_row_open_before_ref", 64'(ib.row_open), 64'd1);
        wait_fire(1'b1, "b_pre", t_pre, e, a, dt, id);
        check_val("b_pre_enc", 64'(e), 64'(CMD_PRE));
        check_val("b_pre_cycle", 64'(t_pre), 64'(d + 1));
        wait_fire(1'b1, "b_ref", f, e, a, dt, id);
        check_val("b_ref_enc", 64'(e), 64'(CMD_REF));
        check_val("b_ref_cycle", 64'(f), 64'(t_pre + 14));
        check_val("b_ref_addr", 64'(a), 64'd0);
        check_val("b_ref_data", 64'(dt), 64'd0);
        check_val("b_ref_id", 64'(id), 64'd0);
        seen = 1'b0; r = -1;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (ib.req_ready) begin
                seen = 1'b1;
                r    = cyc;
            end
        end
        check_val("b_ready_return", 64'(seen), 64'd1);
        check_val("b_ready_return_cycle", 64'(r), 64'(f + 10));
        check_val("b_row_closed_after_ref", 64'(ib.row_open), 64'd0);

        // ---- Closed bank read: ACT then READ after tRCD ----
        send_req(1'b0, "rd1", 1'b0, 32'h0000_0400, 32'h0, 32'd7, acc);
        wait_fire(1'b0, "rd1_act", t_act, e, a, dt, id);
        check_val("rd1_act_enc", 64'(e), 64'(CMD_ACT));
        check_val("rd1_act_cycle", 64'(t_act), 64'(acc + 1));
        wait_fire(1'b0, "rd1_read", f, e, a, dt, id);
        check_val("rd1_read_enc", 64'(e), 64'(CMD_RD));
        check_val("rd1_read_cycle", 64'(f), 64'(t_act + 14));
        check_val("rd1_read_addr", 64'(a), 64'h400);
        check_val("rd1_read_id", 64'(id), 64'd7);
        @(negedge clk);
        check_val("rd1_row_open", 64'(ia.row_open), 64'd1);
        check_val("rd1_open_row", 64'(ia.open_row), 64'd1);

        // ---- Row hit write: WRITE only, valid one cycle after accept ----
        send_req(1'b0, "wr1", 1'b1, 32'h0000_0404, 32'hCAFE_F00D, 32'd8, acc);
        @(negedge clk);
        check_val("wr1_valid", 64'(ia.cmd_valid), 64'd1);
        check_val("wr1_cycle", 64'(cyc), 64'(acc + 1));
        check_val("wr1_enc", 64'(enc_of(1'b0)), 64'(CMD_WR));
        check_val("wr1_addr", 64'(ia.cmd_addr), 64'h404);
        check_val("wr1_data", 64'(ia.cmd_data), 64'hCAFE_F00D);
        check_val("wr1_id", 64'(ia.cmd_request_id), 64'd8);
        $display("[TB] wr1: cmd %04b addr=0x%08h id=%0d fired at cycle %0d",
                 enc_of(1'b0), ia.cmd_addr, ia.cmd_request_id, cyc);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("wr1_after_valid", 64'(ia.cmd_valid), 64'd0);
        check_val("wr1_after_nop", 64'(enc_of(1'b0)), 64'hF);

        // ---- Row miss soon after ACT: PRE gated by tRAS ----
        send_req(1'b0, "rd2", 1'b0, 32'h0000_0800, 32'h0, 32'd9, acc);
        wait_fire(1'b0, "rd2_pre", t_pre, e, a, dt, id);
        check_val("rd2_pre_enc", 64'(e), 64'(CMD_PRE));
        check_val("rd2_pre_cycle", 64'(t_pre), 64'(t_act + 33));
        wait_fire(1'b0, "rd2_act", t_act, e, a, dt, id);
        check_val("rd2_act_enc", 64'(e), 64'(CMD_ACT));
        check_val("rd2_act_cycle", 64'(t_act), 64'(t_pre + 14));
        wait_fire(1'b0, "rd2_read", f, e, a, dt, id);
        check_val("rd2_read_enc", 64'(e), 64'(CMD_RD));
        check_val("rd2_read_cycle", 64'(f), 64'(t_act + 14));
        check_val("rd2_read_id", 64'(id), 64'd9);
        check_val("rd2_open_row", 64'(ia.open_row), 64'd2);

        // ---- Backpressure on ACTIVATE ----
        send_req(1'b0, "rd3", 1'b0, 32'h0000_0C00, 32'h0, 32'd11, acc);
        wait_fire(1'b0, "rd3_pre", t_pre, e, a, dt, id);
        ia.cmd_ready = 1'b0;
        seen = 1'b0; v = -1;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (ia.cmd_valid) begin
                seen = 1'b1;
                v    = cyc;
            end
        end
        check_val("bp_valid_seen", 64'(seen), 64'd1);
        check_val("bp_valid_cycle", 64'(v), 64'(t_pre + 14));
        check_val("bp_enc", 64'(enc_of(1'b0)), 64'(CMD_ACT));
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_hold_valid", 64'(ia.cmd_valid), 64'd1);
            check_val("bp_hold_enc", 64'(enc_of(1'b0)), 64'(CMD_ACT));
            check_val("bp_hold_addr", 64'(ia.cmd_addr), 64'hC00);
        end
        @(posedge clk);
        #1;
        ia.cmd_ready = 1'b1;
        wait_fire(1'b0, "rd3_act", t_act, e, a, dt, id);
        check_val("bp_act_enc", 64'(e), 64'(CMD_ACT));
        check_val("bp_act_cycle", 64'(t_act), 64'(v + 5));
        wait_fire(1'b0, "rd3_read", f, e, a, dt, id);
        check_val("bp_next_is_read", 64'(e), 64'(CMD_RD));
        check_val("bp_read_cycle", 64'(f), 64'(t_act + 14));
        check_val("bp_read_id", 64'(id), 64'd11);

        // ---- Reset during ACT_WAIT ----
        send_req(1'b0, "rd4", 1'b0, 32'h0000_1000, 32'h0, 32'd12, acc);
        wait_fire(1'b0, "rd4_pre", t_pre, e, a, dt, id);
        wait_fire(1'b0, "rd4_act", t_act, e, a, dt, id);
        @(negedge clk);
        check_val("actwait_busy", 64'(ia.busy), 64'd1);
        check_val("actwait_no_valid", 64'(ia.cmd_valid), 64'd0);
        #1;
        rst_a = 1'b1;
        #1;
        check_val("midrst_cmd_valid", 64'(ia.cmd_valid), 64'd0);
        check_val("midrst_bus_nop", 64'(enc_of(1'b0)), 64'hF);
        check_val("midrst_row_open", 64'(ia.row_open), 64'd0);
        check_val("midrst_busy", 64'(ia.busy), 64'd0);
        check_val("midrst_req_ready", 64'(ia.req_ready), 64'd0);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check_val("postrst_open_row", 64'(ia.open_row), 64'd0);
        send_req(1'b0, "rd5", 1'b0, 32'h0000_2000, 32'h0, 32'd13, acc);
        wait_fire(1'b0, "rd5_act", t_act, e, a, dt, id);
        check_val("rd5_act_enc", 64'(e), 64'(CMD_ACT));
        check_val("rd5_act_addr", 64'(a), 64'h2000);
        check_val("rd5_act_cycle", 64'(t_act), 64'(acc + 1));
        wait_fire(1'b0, "rd5_read", f, e, a, dt, id);
        check_val("rd5_read_enc", 64'(e), 64'(CMD_RD));
        check_val("rd5_read_id", 64'(id), 64'd13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bank_command_sequencer.md
Name: bank_command_sequencer

Overview:
- Per-bank stage that sits directly upstream of the per-bank request-statistics logger.
- Accepts physical memory requests (read/write, address, data, id) over valid/ready.
- Converts each request into a timed DRAM command stream (ACTIVATE, READ/WRITE, PRECHARGE, REFRESH) on the cs/ras/cas/we bus, using an open-page policy with periodic refresh.
- Its cmd_valid & cmd_ready is the req_fire seen by the logger.

Parameters:
- RANK, 0, rank index (carried for instance identification).
- BANKGROUP, 0, bank-group index.
- BANK, 0, bank index.
- ROW_SHIFT, 10, LSB position of the row field in the address.
- ROW_BITS, 14, row field width; row = addr[ROW_SHIFT+ROW_BITS-1:ROW_SHIFT].
- T_RCD, 14, minimum cycles from ACTIVATE fire to column-command fire.
- T_RP, 14, minimum cycles from PRECHARGE fire to ACTIVATE or REFRESH fire.
- T_RAS, 33, minimum cycles from ACTIVATE fire to PRECHARGE fire.
- T_RFC, 160, cycles from REFRESH fire until the bank is usable.
- T_REFI, 3900, refresh interval in cycles.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-high reset.
- req_valid, in, 1, request valid.
- req_ready, out, 1, request accepted when valid & ready.
- req_is_write, in, 1, 1 = write, 0 = read.
- req_addr, in, 32, physical address.
- req_data, in, 32, write data.
- req_id, in, 32, request id.
- cmd_valid, out, 1, command valid.
- cmd_ready, in, 1, downstream accepts the command.
- cmd_addr, out, 32, address of the command.
- cmd_data, out, 32, data of the command.
- cmd_request_id, out, 32, id of the command.
- cmd_cs, out, 1, chip-select line of the command encoding.
- cmd_ras, out, 1, RAS line of the command encoding.
- cmd_cas, out, 1, CAS line of the command encoding.
- cmd_we, out, 1, WE line of the command encoding.
- row_open, out, 1, a row is currently open.
- open_row, out, ROW_BITS, currently open row.
- busy, out, 1, state != IDLE.

Behaviour:
- Command encoding {cs,ras,cas,we}:
  - REFRESH = 0001
  - PRECHARGE = 0010
  - ACTIVATE = 0011
  - READ = 0101
  - WRITE = 0100
  - Idle/NOP = 1111
- Reset (async, immediate):
  - state = IDLE; cmd_valid = 0; cmd bus = 1111.
  - cmd_addr, cmd_data, cmd_request_id = 0.
  - row_open = 0; open_row = 0; all timers = 0; refresh_pending = 0.
  - req_ready forced 0 while reset is high.
  - Reset mid-operation drops the in-flight request; no command is emitted for it.
- req_ready = (state == IDLE) && !refresh_pending && !reset. It is combinational.
- On accept, latch is_write, addr, data and id.
- Next state from IDLE:
  - row_open and row match → COL.
  - row_open and mismatch → PRE.
  - otherwise → ACT.
- States:
  - IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, COL, REF, REF_WAIT.
- Issue states (PRE, ACT, COL, REF):
  - Assert cmd_valid only once that state's timing constraint is met.
  - While cmd_valid && !cmd_ready, hold the command and all payload stable.
  - Never withdraw cmd_valid once asserted.
  - Fire = cmd_valid & cmd_ready.
  - In the cycle after fire, cmd_valid = 0 and the bus returns to 1111.
- PRE:
  - Precondition: ras_timer == 0 before asserting cmd_valid.
  - On fire: row_open = 0; load wait_timer = T_RP-1; → PRE_WAIT.
  - Then → ACT, or → REF if on the refresh path.
- ACT:
  - On fire: row_open = 1; open_row = latched row; wait_timer = T_RCD-1; ras_timer = T_RAS-1; → ACT_WAIT → COL.
- COL:
  - Issues READ or WRITE with the latched payload.
  - On fire → IDLE; the row stays open.
- Timer semantics:
  - A wait state exits in the cycle its timer reads 0.
  - The next command therefore fires no earlier than T_x cycles after the previous fire.
  - ras_timer decrements independently and saturates at 0.
- Refresh:
  - refi_cnt counts up every cycle.
  - At T_REFI-1: set refresh_pending and wrap to 0.
  - In IDLE with refresh_pending: if row_open → PRE (refresh path); else → REF.
  - REF fire clears refresh_pending, loads wait_timer = T_RFC-1, → REF_WAIT → IDLE.
  - REFRESH commands carry addr 0, data 0, id 0.
- Simultaneous events:
  - If refresh_pending sets in the same cycle as a request accept, the request completes first; refresh follows.
  - A second interval expiry while refresh is already pending is absorbed (single pending flag).
- Width rules:
  - All timers are 16 bits.
  - Parameter values must be ≥ 1; T_REFI must be > T_RFC.

Decomposition:
- Shared package (dram_cmd_pkg):
  - Command enum and its 4-bit encodings.
  - State enum.
  - Localparam for the NOP encoding.
- One natural sub-module: bank_timer, a loadable 16-bit down counter with a zero flag.
  - Instantiated twice: wait_timer and ras_timer.

Test Plan:
- Defaults, bank closed, read addr 0x0000_0400 id 7, cmd_ready = 1:
  - ACTIVATE row 1 fires at cycle t.
  - READ fires at t+14 with addr 0x400, id 7.
  - row_open = 1, open_row = 1.
- Follow-up write to addr 0x0000_0404 (same row):
  - WRITE is the only command emitted, first cmd_valid one cycle after accept, no ACT/PRE.
- Follow-up read to 0x0000_0800 (row 2) immediately after an ACT at t:
  - PRECHARGE fires at ≥ t+33.
  - ACTIVATE fires at PRE+14.
  - READ fires at ACT+14.
- Backpressure:
  - Hold cmd_ready = 0 for 5 cycles on an ACTIVATE.
  - cmd_valid and bus 0011 stay stable; exactly one fire is seen.
- T_REFI = 50, T_RFC = 10, row open:
  - req_ready drops.
  - PRECHARGE, then REFRESH (0001) after 14 cycles, then req_ready returns 10 cycles after REFRESH.
- Assert reset during ACT_WAIT:
  - Outputs immediately go to cmd_valid = 0, bus 1111, row_open = 0.
  - After release, a new request starts with ACTIVATE.
